// File: rtl/regfile_pkg.sv
// Shared defaults, address type and write-legality helper for the 2-read/1-write register file.
package regfile_pkg;

  localparam int REGFILE_WIDTH_DEFAULT = 64;
  localparam int REGFILE_DEPTH_DEFAULT = 32;

  // Wide enough to carry any instance's address without truncation.
  typedef logic [31:0] regfile_addr_t;

  function automatic logic regfile_addr_ok(regfile_addr_t addr, int depth, logic zero_reg);
    regfile_addr_t top;
    top = regfile_addr_t'(depth - 1);
    return (addr <= top) && !(zero_reg && (addr == top));
  endfunction

endpackage

// File: rtl/regfile_2r1w_mux_tree.sv
// Combinational N_IN:1 selector of DW-bit words built as log2 levels of 2:1 muxes.
// Select MSB steers the first level, LSB the last; unpopulated leaves read as zero.
module mux_tree
  import regfile_pkg::*;
#(
  parameter int N_IN = 32,
  parameter int DW   = 1,
  localparam int SW     = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int LEAVES = 1 << SW
) (
  input  logic [N_IN*DW-1:0] in,
  input  logic [SW-1:0]      s,
  output logic [DW-1:0]      out
);

  // Level k occupies node[2*LEAVES - 2*(LEAVES>>k) +: LEAVES>>k]; the root is the last node.
  logic [DW-1:0] node [2*LEAVES-1];

  genvar gi, gl;
  generate
    for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
      if (gi < N_IN) begin : g_used
        assign node[gi] = in[gi*DW +: DW];
      end else begin : g_pad
        assign node[gi] = '0;
      end
    end

    for (gl = 1; gl <= SW; gl++) begin : g_level
      localparam int HALF    = LEAVES >> gl;
      localparam int OFF_IN  = 2*LEAVES - 2*(LEAVES >> (gl-1));
      localparam int OFF_OUT = 2*LEAVES - 2*(LEAVES >> gl);
      for (gi = 0; gi < HALF; gi++) begin : g_mux
        assign node[OFF_OUT+gi] = s[SW-gl] ? node[OFF_IN+gi+HALF] : node[OFF_IN+gi];
      end
    end
  endgenerate

  assign out = node[2*LEAVES-2];

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with registered read outputs and optional hardwired-zero top entry.
// Define REGFILE_WR_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH_DEFAULT,
  parameter int DEPTH    = REGFILE_DEPTH_DEFAULT,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_valid
);

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [DEPTH*WIDTH-1:0] mem_flat;
  logic [WIDTH-1:0]       sel_a, sel_b;
  logic [WIDTH-1:0]       rd_data_a_d, rd_data_b_d;
  logic [WIDTH-1:0]       rd_data_a_q, rd_data_b_q;
  logic                   rd_valid_q;
  logic                   wr_ok;

  // The protected entry is never written, so it keeps its reset value of zero.
  assign wr_ok = wr_en && regfile_addr_ok(regfile_addr_t'(wr_addr), DEPTH, ZERO_REG != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign mem_flat[gi*WIDTH +: WIDTH] = mem_q[gi];
    end
  endgenerate

  mux_tree #(.N_IN(DEPTH), .DW(WIDTH)) u_mux_a (
    .in  (mem_flat),
    .s   (rd_addr_a),
    .out (sel_a)
  );

  mux_tree #(.N_IN(DEPTH), .DW(WIDTH)) u_mux_b (
    .in  (mem_flat),
    .s   (rd_addr_b),
    .out (sel_b)
  );

`ifdef REGFILE_WR_BYPASS_EN
  always_comb begin
    rd_data_a_d = sel_a;
    rd_data_b_d = sel_b;
    if (wr_ok && (rd_addr_a == wr_addr)) rd_data_a_d = wr_data;
    if (wr_ok && (rd_addr_b == wr_addr)) rd_data_b_d = wr_data;
  end
`else
  assign rd_data_a_d = sel_a;
  assign rd_data_b_d = sel_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_a_q <= rd_data_a_d;
        rd_data_b_q <= rd_data_b_d;
      end
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_valid  = rd_valid_q;

endmodule
